// File: rtl/rio_pkg.sv
// Shared definitions for the RIO output path.
//   out_state_e : output conditioner state encoding (OFF / ON / FAULT)
//   fits_width  : true when a value is representable in an unsigned field of the given width
package rio_pkg;

  typedef enum logic [1:0] {
    OUT_OFF   = 2'd0,
    OUT_ON    = 2'd1,
    OUT_FAULT = 2'd2
  } out_state_e;

  function automatic logic fits_width(input int unsigned value, input int unsigned width);
    if (width >= 32) begin
      return 1'b1;
    end
    return (value >> width) == 0;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Saturating up-counter used to time how long the output has been in its current state.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset, clears the count
//   clear : synchronous clear, takes priority over counting
//   count : current count, holds at all-ones instead of wrapping
module dwell_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_q != {WIDTH{1'b1}}) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/output_dwell.sv
// Output-side conditioner for a digital output pin (relay, solenoid, spindle enable).
// Enforces minimum on/off dwell times, an optional max-on watchdog with a latched fault, and
// optional pin inversion for sink drivers.
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   SIGNAL     : requested output level (1 = active)
//   fault_clr  : single-cycle request to clear a latched watchdog fault
//   SIGNAL_out : registered physical pin drive
//   busy       : request differs from current state but is held off by a dwell
//   fault      : watchdog fault latched
module output_dwell
  import rio_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MIN_ON  = 1000,
  parameter int unsigned MIN_OFF = 1000,
  parameter int unsigned MAX_ON  = 0,
  parameter int unsigned INVERT  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SIGNAL,
  input  logic fault_clr,
  output logic SIGNAL_out,
  output logic busy,
  output logic fault
);

  if (!fits_width(MIN_ON, WIDTH)) begin : gen_chk_min_on
    $error("output_dwell: MIN_ON does not fit in WIDTH bits");
  end
  if (!fits_width(MIN_OFF, WIDTH)) begin : gen_chk_min_off
    $error("output_dwell: MIN_OFF does not fit in WIDTH bits");
  end
  if (!fits_width(MAX_ON, WIDTH)) begin : gen_chk_max_on
    $error("output_dwell: MAX_ON does not fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] MinOnC  = WIDTH'(MIN_ON);
  localparam logic [WIDTH-1:0] MinOffC = WIDTH'(MIN_OFF);
  localparam logic [WIDTH-1:0] MaxOnC  = WIDTH'(MAX_ON);
  localparam logic             WdogEn  = (MAX_ON != 0);
  localparam logic             InvC    = (INVERT != 0);

  out_state_e       state_q, state_d;
  logic             req_q;
  logic             pin_q;
  logic             cnt_clear;
  logic [WIDTH-1:0] cnt;

  dwell_counter #(
    .WIDTH (WIDTH)
  ) u_dwell_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .count (cnt)
  );

  // Transition decisions all use the registered request and the pre-edge count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OUT_OFF: begin
        if (req_q && (cnt >= MinOffC)) begin
          state_d = OUT_ON;
        end
      end
      OUT_ON: begin
        // Watchdog expiry beats a simultaneous request drop.
        if (WdogEn && (cnt >= MaxOnC)) begin
          state_d = OUT_FAULT;
        end else if (!req_q && (cnt >= MinOnC)) begin
          state_d = OUT_OFF;
        end
      end
      OUT_FAULT: begin
        // Clearing while still requested is ignored so the load cannot auto-restart.
        if (fault_clr && !req_q) begin
          state_d = OUT_OFF;
        end
      end
      default: begin
        state_d = OUT_OFF;
      end
    endcase
  end

  // Every state change restarts the dwell timer, including FAULT -> OFF.
  assign cnt_clear = (state_d != state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OUT_OFF;
      req_q   <= 1'b0;
      pin_q   <= InvC;
    end else begin
      state_q <= state_d;
      req_q   <= SIGNAL;
      pin_q   <= (state_d == OUT_ON) ^ InvC;
    end
  end

  assign SIGNAL_out = pin_q;
  assign fault      = (state_q == OUT_FAULT);
  assign busy       = ((state_q == OUT_OFF) && req_q && (cnt < MinOffC)) ||
                      ((state_q == OUT_ON) && !req_q && (cnt < MinOnC));

endmodule

// File: tb/tb_output_dwell.sv
// Bench for output_dwell: instance A (MAX_ON=20, INVERT=0) and instance B (MAX_ON=0, INVERT=1)
// share clock and reset; a behavioural model predicts both and is compared every cycle, with
// hand-computed literal checks along the directed sequence.
module tb_output_dwell;

  logic clk = 1'b0;
  logic rst_n;
  logic sig_a, clr_a, out_a, busy_a, fault_a;
  logic sig_b, clr_b, out_b, busy_b, fault_b;
  bit   run = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  output_dwell #(
    .WIDTH   (8),
    .MIN_ON  (4),
    .MIN_OFF (6),
    .MAX_ON  (20),
    .INVERT  (0)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .SIGNAL     (sig_a),
    .fault_clr  (clr_a),
    .SIGNAL_out (out_a),
    .busy       (busy_a),
    .fault      (fault_a)
  );

  output_dwell #(
    .WIDTH   (8),
    .MIN_ON  (4),
    .MIN_OFF (6),
    .MAX_ON  (0),
    .INVERT  (1)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .SIGNAL     (sig_b),
    .fault_clr  (clr_b),
    .SIGNAL_out (out_b),
    .busy       (busy_b),
    .fault      (fault_b)
  );

  // Model: whether the load is energised, whether a fault is latched, and how many cycles
  // have passed since the last change (unbounded integer, thresholds are all far below 255).
  int p_min_on[2]  = '{4, 4};
  int p_min_off[2] = '{6, 6};
  int p_max_on[2]  = '{20, 0};
  int p_inv[2]     = '{0, 1};

  bit m_req[2];
  bit m_on[2];
  bit m_flt[2];
  int m_age[2];

  task automatic model_step(input int i, input bit sig, input bit clr);
    bit changed;
    changed = 1'b0;
    if (m_flt[i]) begin
      if (clr && !m_req[i]) begin
        m_flt[i] = 1'b0;
        changed  = 1'b1;
      end
    end else if (m_on[i]) begin
      if (p_max_on[i] != 0 && m_age[i] >= p_max_on[i]) begin
        m_on[i]  = 1'b0;
        m_flt[i] = 1'b1;
        changed  = 1'b1;
      end else if (!m_req[i] && m_age[i] >= p_min_on[i]) begin
        m_on[i] = 1'b0;
        changed = 1'b1;
      end
    end else if (m_req[i] && m_age[i] >= p_min_off[i]) begin
      m_on[i] = 1'b1;
      changed = 1'b1;
    end
    m_age[i] = changed ? 0 : m_age[i] + 1;
    m_req[i] = sig;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_req[i] = 1'b0;
        m_on[i]  = 1'b0;
        m_flt[i] = 1'b0;
        m_age[i] = 0;
      end
    end else begin
      model_step(0, sig_a, clr_a);
      model_step(1, sig_b, clr_b);
    end
  end

  function automatic bit exp_busy(input int i);
    return (!m_on[i] && !m_flt[i] && m_req[i] && m_age[i] < p_min_off[i]) ||
           (m_on[i] && !m_req[i] && m_age[i] < p_min_on[i]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      check("model_a_out",   int'(out_a),   int'(m_on[0] ^ p_inv[0][0]));
      check("model_a_fault", int'(fault_a), int'(m_flt[0]));
      check("model_a_busy",  int'(busy_a),  int'(exp_busy(0)));
      check("model_b_out",   int'(out_b),   int'(m_on[1] ^ p_inv[1][0]));
      check("model_b_fault", int'(fault_b), int'(m_flt[1]));
      check("model_b_busy",  int'(busy_b),  int'(exp_busy(1)));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int hi;

  initial begin
    sig_a = 1'b1;
    sig_b = 1'b1;
    clr_a = 1'b0;
    clr_b = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_a_out", int'(out_a), 0);
    check("reset_b_out", int'(out_b), 1);
    check("reset_a_busy", int'(busy_a), 0);
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: request held from release; MIN_OFF honoured before first activation.
    tick();
    check("t1_busy_edge1", int'(busy_a), 1);
    check("t1_out_edge1", int'(out_a), 0);
    repeat (5) tick();
    check("t1_out_edge6", int'(out_a), 0);
    check("t6_outb_edge6", int'(out_b), 1);
    tick();
    check("t1_out_edge7", int'(out_a), 1);
    check("t6_outb_edge7", int'(out_b), 0);

    // 4: watchdog trips after 21 active cycles; clear ignored while still requested.
    repeat (20) tick();
    check("t4_out_before_wdog", int'(out_a), 1);
    check("t4_fault_before_wdog", int'(fault_a), 0);
    tick();
    check("t4_out_wdog", int'(out_a), 0);
    check("t4_fault_wdog", int'(fault_a), 1);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("t4_clr_ignored", int'(fault_a), 1);
    sig_a = 1'b0;
    tick();
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("t4_clr_taken", int'(fault_a), 0);
    sig_a = 1'b1;
    repeat (6) tick();
    check("t4_reon_early", int'(out_a), 0);
    tick();
    check("t4_reon", int'(out_a), 1);

    // 2: release, let MIN_OFF elapse, then a 1-cycle pulse is stretched to 5 active cycles.
    sig_a = 1'b0;
    repeat (12) tick();
    check("t2_idle", int'(out_a), 0);
    sig_a = 1'b1;
    tick();
    sig_a = 1'b0;
    check("t2_edge1", int'(out_a), 0);
    tick();
    check("t2_edge2", int'(out_a), 1);
    hi = 1;
    repeat (4) begin
      tick();
      hi += int'(out_a);
    end
    tick();
    check("t2_edge7", int'(out_a), 0);
    check("t2_high_cycles", hi, 5);

    // 3: short pulse inside MIN_OFF is dropped but flagged busy.
    sig_a = 1'b1;
    tick();
    check("t3_busy1", int'(busy_a), 1);
    tick();
    check("t3_busy2", int'(busy_a), 1);
    tick();
    check("t3_busy3", int'(busy_a), 1);
    sig_a = 1'b0;
    hi = 0;
    repeat (8) begin
      tick();
      hi += int'(out_a);
    end
    check("t3_dropped", hi, 0);

    // 6: B held active for 300 cycles without a watchdog never faults.
    repeat (300) tick();
    check("t6_no_fault", int'(fault_b), 0);
    check("t6_outb_active", int'(out_b), 0);

    // 5: asynchronous reset mid-ON.
    sig_a = 1'b1;
    repeat (10) tick();
    check("t5_on", int'(out_a), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_out", int'(out_a), 0);
    check("t5_async_fault", int'(fault_a), 0);
    check("t5_async_busy", int'(busy_a), 0);
    check("t5_async_outb", int'(out_b), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    run = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
